// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
//
// Shared definitions for the word-addressed memory subsystem that sits
// upstream of the MDR.
//
// Contents:
//   WORD_W           data word width (32)
//   DEF_ADDR_BITS    default word-address width (array depth 2**DEF_ADDR_BITS)
//   DEF_WAIT_CYCLES  default number of wait states per access
//   CNT_W            width of the wait-state counter (holds 0..15)
//   mem_state_e      access FSM state encoding
//   addr_in_range()  true when the upper address bits above the array are 0
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int WORD_W          = 32;
    localparam int DEF_ADDR_BITS   = 9;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;

    // Fixed 2-bit encoding so the debug state output has a stable meaning.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_e;

    // An address is legal only if every bit above the array index is zero;
    // addresses are never aliased into the array.
    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                           input int                addr_bits);
        logic [WORD_W-1:0] upper;
        upper = addr >> addr_bits;
        return (upper == '0);
    endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
//
// Single-port synchronous RAM, 2**ADDR_BITS words of WORD_W bits.
// Contents are never reset; they start at zero.
// The read-data register is cleared by rst_i and only updates on an enabled
// read, so it holds the last read word indefinitely.
//
// Ports:
//   clk     in   clock, all activity on the rising edge
//   rst_i   in   synchronous active-high clear of the read-data register only
//   en_i    in   access enable for this cycle
//   we_i    in   1 = write din_i to addr_i, 0 = read addr_i into dout_o
//   addr_i  in   word address
//   din_i   in   write data
//   dout_o  out  registered read data
// -----------------------------------------------------------------------------
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter int    ADDR_BITS = DEF_ADDR_BITS,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [WORD_W-1:0]    din_i,
  output logic [WORD_W-1:0]    dout_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] dout_q;

  // Elaboration-time contents: zero fill.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] = '0;
    end
  end

  // Array write port; no reset so contents survive a clr.
  always @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  // Read register: cleared on reset, otherwise only loaded by a read.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      dout_q <= '0;
    end else if (en_i && !we_i) begin
      dout_q <= mem_q[addr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/mem_interface.sv
// -----------------------------------------------------------------------------
// mem_interface
//
// Word-addressed memory subsystem between the MAR/MDR and the internal RAM.
// A level request (read or write) is accepted from IDLE when the interface is
// armed; the address, write data and op are latched, WAIT_CYCLES wait states
// elapse, the array is accessed for exactly one cycle, and a one-cycle
// mem_ready pulse (with addr_err when rejected) completes the transfer.
//
// Handshake: read/write are levels sampled only in IDLE. Acceptance clears
// the arm flag; it is set again only by an IDLE edge with read=0 and write=0,
// so a request held across completion is serviced exactly once. mem_ready is
// high for one cycle per accepted request; busy is high from the cycle after
// acceptance through the mem_ready cycle. Inputs are ignored while busy.
//
// Ports:
//   clk          in   system clock, rising edge
//   clr          in   synchronous active-high reset (array contents kept)
//   mar_addr     in   32-bit word address
//   mdr_data     in   32-bit write data
//   read         in   read request (level)
//   write        in   write request (level)
//   mdatain      out  last successfully read word (0 after reset)
//   mem_ready    out  one-cycle completion pulse
//   busy         out  request in progress
//   addr_err     out  one-cycle pulse with mem_ready when access was rejected
//   dbg_state_o  out  current FSM state (IDLE=0, WAIT=1, ACCESS=2, DONE=3)
// -----------------------------------------------------------------------------
module mem_interface
    import cpu_mem_pkg::*;
#(
    parameter int    ADDR_BITS   = DEF_ADDR_BITS,
    parameter int    WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WORD_W-1:0] mar_addr,
    input  logic [WORD_W-1:0] mdr_data,
    input  logic              read,
    input  logic              write,
    output logic [WORD_W-1:0] mdatain,
    output logic              mem_ready,
    output logic              busy,
    output logic              addr_err,
    output logic [1:0]        dbg_state_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              armed_q, armed_d;
    logic [WORD_W-1:0] addr_q,  addr_d;
    logic [WORD_W-1:0] data_q,  data_d;
    logic              rd_q,    rd_d;
    logic              wr_q,    wr_d;
    logic              err_q,   err_d;

    logic              req;
    logic              in_range;
    logic              conflict;
    logic              access_ok;
    logic              ram_en;

    assign req       = read | write;
    assign in_range  = addr_in_range(addr_q, ADDR_BITS);
    // Simultaneous read and write is treated as a rejected access.
    assign conflict  = rd_q & wr_q;
    assign access_ok = (state_q == ST_ACCESS) && in_range && !conflict;
    // clr must win over a pending array write in the same cycle.
    assign ram_en    = access_ok && !clr;

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    mem_array #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_mem_array (
        .clk    (clk),
        .rst_i  (clr),
        .en_i   (ram_en),
        .we_i   (wr_q),
        .addr_i (addr_q[ADDR_BITS-1:0]),
        .din_i  (data_q),
        .dout_o (mdatain)
    );

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && req) begin
                    addr_d  = mar_addr;
                    data_d  = mdr_data;
                    rd_d    = read;
                    wr_d    = write;
                    cnt_d   = CNT_LOAD;
                    armed_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end else if (!req) begin
                    armed_d = 1'b1;
                end
            end

            ST_WAIT: begin
                // The edge that takes the counter from 1 to 0 also enters
                // ACCESS, so exactly WAIT_CYCLES cycles are spent here.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                err_d   = conflict || !in_range;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                // Arm flag is left alone here: a request still held now
                // must see a low level in IDLE before it can be accepted.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state_q != ST_IDLE);
        mem_ready   = (state_q == ST_DONE);
        addr_err    = (state_q == ST_DONE) && err_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_mem_interface.sv
// -----------------------------------------------------------------------------
// tb_mem_interface
//
// Two instances share one set of inputs: u_dut_w2 (WAIT_CYCLES=2) and
// u_dut_w0 (WAIT_CYCLES=0). A transaction-level model tracks, per instance,
// the acceptance edge, the completion edge (acceptance + WAIT_CYCLES + 1),
// a word array and the last read value; every cycle after the first reset
// all outputs of both instances are compared against it. Directed sequences
// pin the model with literal latencies and data values.
// -----------------------------------------------------------------------------
module tb_mem_interface;

    localparam int AB    = 9;
    localparam int DEPTH = 1 << AB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr      = 1'b1;
    logic        read     = 1'b0;
    logic        write    = 1'b0;
    logic [31:0] mar_addr = '0;
    logic [31:0] mdr_data = '0;

    logic [31:0] mdatain_a, mdatain_b;
    logic        ready_a, ready_b, busy_a, busy_b, err_a, err_b;
    logic [1:0]  st_a, st_b;

    mem_interface #(.ADDR_BITS(AB), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut_w2 (
        .clk(clk), .clr(clr), .mar_addr(mar_addr), .mdr_data(mdr_data),
        .read(read), .write(write), .mdatain(mdatain_a), .mem_ready(ready_a),
        .busy(busy_a), .addr_err(err_a), .dbg_state_o(st_a)
    );

    mem_interface #(.ADDR_BITS(AB), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut_w0 (
        .clk(clk), .clr(clr), .mar_addr(mar_addr), .mdr_data(mdr_data),
        .read(read), .write(write), .mdatain(mdatain_b), .mem_ready(ready_b),
        .busy(busy_b), .addr_err(err_b), .dbg_state_o(st_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem  [2][DEPTH];
    logic        m_busy [2];
    logic        m_armed[2];
    logic        m_ready[2];
    logic        m_err  [2];
    logic [31:0] m_dat  [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic        m_rd   [2];
    logic        m_wr   [2];
    int          m_done [2];
    int          edge_n = 0;
    logic        rej;

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
            m_busy[k] = 1'b0; m_armed[k] = 1'b1; m_ready[k] = 1'b0;
            m_err[k] = 1'b0; m_dat[k] = '0; m_done[k] = 0;
            m_addr[k] = '0; m_wd[k] = '0; m_rd[k] = 1'b0; m_wr[k] = 1'b0;
        end
    end

    always @(posedge clk) begin
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_busy[k] = 1'b0; m_armed[k] = 1'b1; m_ready[k] = 1'b0;
                m_err[k] = 1'b0; m_dat[k] = '0;
            end else if (!m_busy[k]) begin
                if (m_armed[k] && (read || write)) begin
                    m_busy[k]  = 1'b1;
                    m_armed[k] = 1'b0;
                    m_done[k]  = edge_n + ((k == 0) ? 2 : 0) + 1;
                    m_addr[k]  = mar_addr;
                    m_wd[k]    = mdr_data;
                    m_rd[k]    = read;
                    m_wr[k]    = write;
                end else if (!read && !write) begin
                    m_armed[k] = 1'b1;
                end
            end else if (edge_n == m_done[k]) begin
                rej = (m_rd[k] && m_wr[k]) || (m_addr[k] >= DEPTH);
                if (!rej) begin
                    if (m_wr[k]) m_mem[k][m_addr[k][AB-1:0]] = m_wd[k];
                    else         m_dat[k] = m_mem[k][m_addr[k][AB-1:0]];
                end
                m_ready[k] = 1'b1;
                m_err[k]   = rej;
            end else if (edge_n > m_done[k]) begin
                m_busy[k] = 1'b0; m_ready[k] = 1'b0; m_err[k] = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_w2",    32'(busy_a),  32'(m_busy[0]));
            chk("ready_w2",   32'(ready_a), 32'(m_ready[0]));
            chk("err_w2",     32'(err_a),   32'(m_err[0]));
            chk("mdatain_w2", mdatain_a,    m_dat[0]);
            chk("busy_w0",    32'(busy_b),  32'(m_busy[1]));
            chk("ready_w0",   32'(ready_b), 32'(m_ready[1]));
            chk("err_w0",     32'(err_b),   32'(m_err[1]));
            chk("mdatain_w0", mdatain_b,    m_dat[1]);
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one request, wait for both completions, check literal latency
    // (4 cycles for 2 wait states, 2 cycles for none), error flag and the
    // expected mdatain at completion (front of exp_q), then release.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic exp_err, input string tag);
        int n;
        int lat_a;
        int lat_b;
        logic [31:0] exp_dat;
        exp_dat = exp_q.pop_front();
        @(posedge clk); #2;
        read = rd; write = wr; mar_addr = a; mdr_data = d;
        n = 0; lat_a = -1; lat_b = -1;
        while ((lat_a < 0 || lat_b < 0) && n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (lat_a < 0 && ready_a) begin
                lat_a = n;
                chk({tag, "_err_w2"}, 32'(err_a), 32'(exp_err));
                chk({tag, "_dat_w2"}, mdatain_a, exp_dat);
            end
            if (lat_b < 0 && ready_b) begin
                lat_b = n;
                chk({tag, "_err_w0"}, 32'(err_b), 32'(exp_err));
                chk({tag, "_dat_w0"}, mdatain_b, exp_dat);
            end
        end
        chk({tag, "_lat_w2"}, 32'(lat_a), 32'd4);
        chk({tag, "_lat_w0"}, 32'(lat_b), 32'd2);
        @(posedge clk); #2;
        read = 1'b0; write = 1'b0;
        @(posedge clk);
    endtask

    task automatic count_pulses(input int cycles, output int pa, output int pb);
        pa = 0; pb = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_a) pa++;
            if (ready_b) pb++;
        end
    endtask

    // ---------------- stimulus ----------------
    int pa, pb;
    int r, op, sel;

    initial begin
        // Reset
        clr = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        clr = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy",    32'(busy_a),  32'd0);
        chk("rst_ready",   32'(ready_a), 32'd0);
        chk("rst_err",     32'(err_a),   32'd0);
        chk("rst_mdatain", mdatain_a,    32'd0);
        chk("rst_state",   32'(st_a),    32'd0);

        // Write then read back
        exp_q.push_back(32'h0);
        do_access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "wr10");
        exp_q.push_back(32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, "rd10");
        @(negedge clk);
        chk("rd10_hold", mdatain_a, 32'hDEAD_BEEF);

        // Held request: one access only, re-arm after a low cycle
        @(posedge clk); #2;
        read = 1'b1; mar_addr = 32'h0000_0010;
        count_pulses(12, pa, pb);
        chk("held_pulses_w2", 32'(pa), 32'd1);
        chk("held_pulses_w0", 32'(pb), 32'd1);
        @(posedge clk); #2; read = 1'b0;
        @(posedge clk); #2; read = 1'b1;
        count_pulses(8, pa, pb);
        chk("rearm_pulses_w2", 32'(pa), 32'd1);
        chk("rearm_pulses_w0", 32'(pb), 32'd1);
        @(posedge clk); #2; read = 1'b0;
        @(posedge clk);

        // Out of range
        exp_q.push_back(32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b1, "rd200");
        exp_q.push_back(32'hDEAD_BEEF);
        do_access(1'b0, 1'b1, 32'h0000_0200, 32'h0000_0BAD, 1'b1, "wr200");
        exp_q.push_back(32'h0);
        do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, "rd000");
        exp_q.push_back(32'h0);
        do_access(1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b1, "rdhigh");

        // Conflicting read+write is rejected, array unchanged
        exp_q.push_back(32'h0);
        do_access(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0055, 1'b1, "both");
        exp_q.push_back(32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, "rd10b");

        // Reset while a write is in flight
        exp_q.push_back(32'hDEAD_BEEF);
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0020, 1'b0, "wr20");
        @(posedge clk); #2;
        write = 1'b1; mar_addr = 32'h0000_0020; mdr_data = 32'h1234_5678;
        @(posedge clk); #2;
        clr = 1'b1; write = 1'b0;
        @(posedge clk); #2;
        clr = 1'b0;
        @(negedge clk);
        chk("midrst_busy",    32'(busy_a), 32'd0);
        chk("midrst_mdatain", mdatain_a,   32'd0);
        exp_q.push_back(32'hCAFE_0020);
        do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, "rd20");

        // Zero-wait build exercised alongside: write then read 0x05
        exp_q.push_back(32'hCAFE_0020);
        do_access(1'b0, 1'b1, 32'h0000_0005, 32'hA5A5_0005, 1'b0, "wr05");
        exp_q.push_back(32'hA5A5_0005);
        do_access(1'b1, 1'b0, 32'h0000_0005, 32'h0, 1'b0, "rd05");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            clr = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 9);
            if (r >= 3) begin
                op = $urandom_range(0, 9);
                read  = (op <= 3) || (op == 7);
                write = ((op >= 4) && (op <= 6)) || (op == 7);
                sel = $urandom_range(0, 15);
                if (sel == 0)      mar_addr = 32'h0000_0200 + $urandom_range(0, 7);
                else if (sel == 1) mar_addr = $urandom;
                else if (sel < 5)  mar_addr = 32'h0000_01F0 + $urandom_range(0, 15);
                else               mar_addr = $urandom_range(0, 31);
                mdr_data = $urandom;
            end
        end
        @(posedge clk); #2;
        clr = 1'b0; read = 1'b0; write = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
